mfe_74hc165_input_reader: RTL

//   Reader for 74HC165 parallel-in/serial-out shift-register chains (buttons/switches, MFE I/O boards).

---
 rtl/mfe_74hc165_input_reader_if.sv | 35 +++
 rtl/mfe_74hc165_input_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mfe_74hc165_input_reader_if.sv
// mfe_74hc165_input_reader_if
// Signal bundle between the 74HC165 chain reader and its surroundings.
// master: the reader itself (drives the shift-register control pins and the captured word).
// slave : the environment (scan enable and the serial QH line from the chain).
interface mfe_74hc165_input_reader_if #(
    parameter int BIT_NUM = 8
);
    logic               en;
    logic               qh;
    logic               sclk;
    logic               pl_n;
    logic [BIT_NUM-1:0] dat;
    logic               vld;
    logic               busy;

    modport master (
        input  en,
        input  qh,
        output sclk,
        output pl_n,
        output dat,
        output vld,
        output busy
    );

    modport slave (
        output en,
        output qh,
        input  sclk,
        input  pl_n,
        input  dat,
        input  vld,
        input  busy
    );
endinterface

// File: rtl/mfe_74hc165_input_reader.sv
// mfe_74hc165_input_reader
// Scans a chain of 74HC165 parallel-in/serial-out registers: pulses pl_n to latch the
// inputs, clocks the chain with sclk and assembles one BIT_NUM-bit word per scan.
// The FSM advances on a slow tick (one clk every 2**DIV_WIDTH cycles) so the external
// chain sees wide pulses. All outputs are registered.
// Optional feature: define MFE_74HC165_DEBOUNCE_EN to publish a word only after DEB_CNT
// consecutive identical scans (and only if it differs from the word already published).
module mfe_74hc165_input_reader #(
    parameter int BIT_NUM   = 8,
    parameter int DIV_WIDTH = 8,
    parameter int DEB_CNT   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    mfe_74hc165_input_reader_if.master  bus
);

    localparam int CNT_W = $clog2(BIT_NUM);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_CLK_HI = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_NUM - 1);

    logic                 qh_meta_q;
    logic                 qh_sync_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tick;

    logic [2:0]           state_q, state_d;
    logic                 sclk_q, sclk_d;
    logic                 pl_n_q, pl_n_d;
    logic                 busy_q, busy_d;
    logic [BIT_NUM-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BIT_NUM-1:0]   dat_q, dat_d;
    logic                 vld_q, vld_d;
    logic                 publish;

    // QH comes straight from an external pin, so bring it into the clk domain through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            qh_meta_q <= 1'b0;
            qh_sync_q <= 1'b0;
        end else begin
            qh_meta_q <= bus.qh;
            qh_sync_q <= qh_meta_q;
        end
    end

    // Free-running tick divider; it never restarts on a scan so the tick grid stays fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = &div_q;

    // Next-state logic for the scan FSM, the shift register and the chain control pins.
    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        pl_n_d    = pl_n_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                pl_n_d = 1'b1;
                if (tick && bus.en) begin
                    state_d = ST_LOAD;
                    pl_n_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    state_d = ST_SAMPLE;
                    pl_n_d  = 1'b1;
                end
            end
            ST_SAMPLE: begin
                sclk_d = 1'b0;
                if (tick) begin
                    shreg_d = {shreg_q[BIT_NUM-2:0], qh_sync_q};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_DONE;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_CLK_HI;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                    end
                end
            end
            ST_CLK_HI: begin
                if (tick) begin
                    state_d = ST_SAMPLE;
                    sclk_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                sclk_d    = 1'b0;
                pl_n_d    = 1'b1;
                bit_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifdef MFE_74HC165_DEBOUNCE_EN
    localparam int            DEB_W      = $clog2(DEB_CNT + 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEB_CNT);

    logic [BIT_NUM-1:0] prev_q, prev_d;
    logic [DEB_W-1:0]   stab_q, stab_d;

    // Track how many consecutive scans produced the same word; publish on reaching the target.
    always_comb begin
        prev_d  = prev_q;
        stab_d  = stab_q;
        publish = 1'b0;
        if (state_q == ST_DONE) begin
            if (shreg_q != prev_q) begin
                prev_d = shreg_q;
                stab_d = DEB_W'(1);
            end else if (stab_q != DEB_TARGET) begin
                stab_d = stab_q + 1'b1;
            end
            publish = (stab_d == DEB_TARGET) && (shreg_q != dat_q);
        end
    end

    // Debounce history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            stab_q <= '0;
        end else begin
            prev_q <= prev_d;
            stab_q <= stab_d;
        end
    end
`else
    assign publish = (state_q == ST_DONE);
`endif

    // The captured word only changes together with a single-cycle vld pulse.
    always_comb begin
        dat_d = publish ? shreg_q : dat_q;
        vld_d = publish;
    end

    // State and output registers; reset also aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            pl_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dat_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            pl_n_q    <= pl_n_d;
            busy_q    <= busy_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.pl_n = pl_n_q;
    assign bus.busy = busy_q;
    assign bus.dat  = dat_q;
    assign bus.vld  = vld_q;

endmodule
